// File: rtl/shift_right_seq_16b_pkg.sv
// rtl/shift_right_seq_16b_pkg.sv - shared state encoding and width defaults for the right shifter
package shift_right_seq_16b_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  // 2'd3 is never produced; the FSM decodes it like IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_r1_16b.sv
// rtl/shift_r1_16b.sv - combinational right shift by one place with selectable fill bit
module shift_r1_16b #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);

  // drop the LSB, move everything down one place, insert the fill bit at the top
  always_comb begin
    out            = in >> 1;
    out[WIDTH-1]   = fill;
  end

endmodule

// File: rtl/shift_right_seq_16b.sv
// rtl/shift_right_seq_16b.sv - one-bit-per-clock logical/arithmetic right shifter with start/done handshake
module shift_right_seq_16b
  import shift_right_seq_16b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] amount,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shifted;
  logic             fill;

  // sign-fill only in arithmetic mode; the MSB never changes while shifting, so it still holds the operand sign
  assign fill = mode_q & out_q[WIDTH-1];

  shift_r1_16b #(
    .WIDTH (WIDTH)
  ) u_shift_r1 (
    .in   (out_q),
    .fill (fill),
    .out  (shifted)
  );

  // next-state logic: accept in IDLE/DONE, shift one place per cycle in SHIFT
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    mode_d  = mode_q;
    case (state_q)
      S_SHIFT: begin
        out_d   = shifted;
        count_d = count_q - 1'b1;
        // count of 0 cannot occur here, but leaving SHIFT for it avoids a 2**CNT_W-cycle wrap
        state_d = (count_q <= CNT_W'(1)) ? S_DONE : S_SHIFT;
      end
      default: begin
        if (start) begin
          out_d   = in;
          count_d = amount;
          mode_d  = arith;
          state_d = (amount != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // state, datapath and registered status flags
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_right_seq_16b.sv
// tb/tb_shift_right_seq_16b.sv - scoreboard bench for the sequential right shifter
module tb_shift_right_seq_16b;

  logic        CLK;
  logic        Reset_n;
  logic        start;
  logic [15:0] in_i;
  logic [3:0]  amount_i;
  logic        arith_i;
  logic [15:0] out_o;
  logic        busy_o;
  logic        done_o;

  shift_right_seq_16b dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .start   (start),
    .in      (in_i),
    .amount  (amount_i),
    .arith   (arith_i),
    .out     (out_o),
    .busy    (busy_o),
    .done    (done_o)
  );

  typedef struct {
    logic [15:0] res;
    int          acc;
    int          dn;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [15:0] last_res = 16'h0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a, input logic ar);
    if (ar) return 16'($signed(d) >>> a);
    return d >> a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compares busy, hold behaviour and each done pulse against the scoreboard
  always @(negedge CLK) begin
    if (Reset_n) begin
      logic exp_busy;
      exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].dn);
      chk("busy", 32'(busy_o), 32'(exp_busy));
      if (done_o) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 32'(done_o), 32'(1'b0));
        end else begin
          chk("done_cycle", 32'(cyc), 32'(q[0].dn));
          chk("result", 32'(out_o), 32'(q[0].res));
          last_res = q[0].res;
          void'(q.pop_front());
        end
      end else begin
        if (q.size() > 0 && cyc >= q[0].dn) begin
          chk("done_missing", 32'(done_o), 32'(1'b1));
          void'(q.pop_front());
        end
        if (!busy_o) chk("hold", 32'(out_o), 32'(last_res));
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] a, input logic ar,
                      input bit junk, input logic [15:0] junk_d);
    int n = 0;
    while (busy_o && n < 64) begin
      @(negedge CLK);
      n++;
    end
    if (busy_o) chk("send_wait", 32'(busy_o), 32'(1'b0));
    start    = 1'b1;
    in_i     = d;
    amount_i = a;
    arith_i  = ar;
    q.push_back('{ref_shift(d, a, ar), cyc + 1, cyc + 1 + int'(a)});
    @(negedge CLK);
    if (junk && a != 4'd0) begin
      start    = 1'b1;
      in_i     = junk_d;
      amount_i = 4'($urandom);
      arith_i  = 1'($urandom);
      @(negedge CLK);
    end
    start    = 1'b0;
    in_i     = 16'($urandom);
    amount_i = 4'($urandom);
    arith_i  = 1'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    Reset_n = 1'b0;
    start   = 1'b1;
    #1;
    chk("rst_out", 32'(out_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    q.delete();
    last_res = 16'h0;
    repeat (cycles) begin
      @(negedge CLK);
      chk("rst_hold_out", 32'(out_o), 32'h0);
      chk("rst_hold_busy", 32'(busy_o), 32'h0);
      chk("rst_hold_done", 32'(done_o), 32'h0);
    end
    start   = 1'b0;
    Reset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 64) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 32'(q.size()), 32'h0);
    @(negedge CLK);
  endtask

  initial begin
    Reset_n  = 1'b0;
    start    = 1'b0;
    in_i     = 16'h0;
    amount_i = 4'h0;
    arith_i  = 1'b0;
    do_reset(3);
    send(16'h8000, 4'd4, 1'b0, 1'b0, 16'h0);
    drain();
    send(16'hF000, 4'd3, 1'b1, 1'b0, 16'h0);
    drain();
    send(16'hF000, 4'd15, 1'b1, 1'b0, 16'h0);
    drain();
    send(16'h7FFF, 4'd15, 1'b1, 1'b0, 16'h0);
    send(16'h8000, 4'd15, 1'b0, 1'b0, 16'h0);
    drain();
    send(16'h1234, 4'd0, 1'b0, 1'b0, 16'h0);
    drain();
    send(16'h00F0, 4'd4, 1'b0, 1'b1, 16'hFFFF);
    drain();
    send(16'hA5A5, 4'd3, 1'b1, 1'b0, 16'h0);
    send(16'h0004, 4'd2, 1'b0, 1'b0, 16'h0);
    drain();
    send(16'hFFFF, 4'd10, 1'b0, 1'b0, 16'h0);
    repeat (3) @(negedge CLK);
    do_reset(2);
    send(16'h8000, 4'd4, 1'b0, 1'b0, 16'h0);
    drain();
    for (int i = 0; i < 60; i++) begin
      send(16'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
